// File: rtl/sample_framer.sv
// sample_framer: pairs 16-bit samples into 32-bit words, buffers them, and emits
// header / payload / checksum frames on a valid/ready output.
module sample_framer #(
    parameter int         FRAME_WORDS = 4,
    parameter int         FIFO_DEPTH  = 8,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_first,
    output logic        out_last,
    output logic [7:0]  frame_seq
);
    localparam int             AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int             CW       = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0]  DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]  FW_C     = CW'(FRAME_WORDS);
    localparam logic [AW-1:0]  TOP_PTR  = AW'(FIFO_DEPTH - 1);
    localparam logic [15:0]    LAST_IDX = 16'(FRAME_WORDS - 1);
    localparam logic [15:0]    FW_FIELD = 16'(FRAME_WORDS);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, CHECKSUM} state_t;

    state_t        r_state;
    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [15:0]   r_hold;
    logic          r_hold_vld;
    logic          r_run;
    logic [15:0]   r_idx;
    logic [31:0]   r_csum;
    logic [31:0]   r_data;
    logic          r_valid;
    logic          r_first;
    logic          r_last;
    logic [7:0]    r_seq;

    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic [AW-1:0] w_wptr_nxt;
    logic [AW-1:0] w_rptr_nxt;
    logic [31:0]   w_sum;

    assign in_ready   = r_run && (r_count < DEPTH_C);
    assign w_accept   = in_valid && in_ready;
    assign w_push     = w_accept && r_hold_vld;
    assign w_pop      = (r_state == PAYLOAD) && out_ready;
    assign w_wptr_nxt = (r_wptr == TOP_PTR) ? '0 : r_wptr + 1'b1;
    assign w_rptr_nxt = (r_rptr == TOP_PTR) ? '0 : r_rptr + 1'b1;
    assign w_sum      = r_csum + r_data;

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_first = r_first;
    assign out_last  = r_last;
    assign frame_seq = r_seq;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {in_data, r_hold};
    end

    // Pair holder and FIFO bookkeeping; a push and a pop in one cycle cancel in the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run      <= 1'b0;
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_accept) begin
                r_hold_vld <= !r_hold_vld;
                if (!r_hold_vld) r_hold <= in_data;
            end
            if (w_push) r_wptr <= w_wptr_nxt;
            if (w_pop) r_rptr <= w_rptr_nxt;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // A frame only starts once its whole payload is buffered, so the next head is always valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
            r_csum  <= '0;
            r_idx   <= '0;
            r_seq   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_count >= FW_C) begin
                        r_state <= HEADER;
                        r_valid <= 1'b1;
                        r_first <= 1'b1;
                        r_data  <= {SYNC_BYTE, r_seq, FW_FIELD};
                    end
                end
                HEADER: begin
                    if (out_ready) begin
                        r_state <= PAYLOAD;
                        r_first <= 1'b0;
                        r_data  <= r_mem[r_rptr];
                        r_csum  <= '0;
                        r_idx   <= '0;
                    end
                end
                PAYLOAD: begin
                    if (out_ready) begin
                        r_csum <= w_sum;
                        r_idx  <= r_idx + 1'b1;
                        if (r_idx == LAST_IDX) begin
                            r_state <= CHECKSUM;
                            r_last  <= 1'b1;
                            r_data  <= w_sum;
                        end else begin
                            r_data <= r_mem[w_rptr_nxt];
                        end
                    end
                end
                CHECKSUM: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_data  <= '0;
                        r_seq   <= r_seq + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sample_framer.sv
// tb_sample_framer: randomized scenarios checked against a queue-based frame model.
module tb_sample_framer;
    localparam int FW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_first;
    logic        out_last;
    logic [7:0]  frame_seq;

    int n_assert = 0;
    int n_fail = 0;
    int si = 0;
    logic [15:0] stim[$];
    logic [15:0] acc[$];
    logic [33:0] obs[$];
    logic [33:0] exp_q[$];
    logic [35:0] trace[$];

    sample_framer #(.FRAME_WORDS(FW), .FIFO_DEPTH(8), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_first(out_first), .out_last(out_last), .frame_seq(frame_seq)
    );

    always #5 clk = ~clk;

    // Expected output: consecutive sample pairs form words, complete groups of FW form frames.
    task automatic build_exp(input int seq0);
        logic [31:0] w[$];
        logic [31:0] sum;
        exp_q.delete();
        for (int i = 0; i + 1 < acc.size(); i += 2) w.push_back({acc[i+1], acc[i]});
        for (int f = 0; f < w.size() / FW; f++) begin
            exp_q.push_back({2'b10, 8'hA5, 8'(seq0 + f), 16'(FW)});
            sum = 0;
            for (int k = 0; k < FW; k++) begin
                exp_q.push_back({2'b00, w[f*FW+k]});
                sum += w[f*FW+k];
            end
            exp_q.push_back({2'b01, sum});
        end
    endtask

    task automatic clear_logs();
        stim.delete(); acc.delete(); obs.delete(); trace.delete(); si = 0;
    endtask

    task automatic do_reset();
        in_valid = 0; out_ready = 0; rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        clear_logs();
    endtask

    // mode: 0 ready high, 1 ready toggling, 2 ready random, 3 ready low
    task automatic run(input int mode, input int gap, input int max_cyc, input int want);
        int done_at = -1;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(c % 2 == 0) :
                        (mode == 2) ? 1'($urandom_range(1)) : 1'b0;
            in_valid = (si < stim.size()) && ($urandom_range(99) >= gap);
            in_data = in_valid ? stim[si] : 16'($urandom);
            #1;
            if (in_valid && in_ready) begin acc.push_back(in_data); si++; end
            if (out_valid && out_ready) obs.push_back({out_first, out_last, out_data});
            trace.push_back({out_valid, out_ready, out_first, out_last, out_data});
            if (done_at < 0 && si == stim.size() && obs.size() >= want) done_at = c;
            if (done_at >= 0 && c >= done_at + 8) break;
        end
        in_valid = 0; out_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; in_valid = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        #1;
        n_assert++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_assert++;
        if ({out_valid, out_first, out_last, out_data, frame_seq} !== 43'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v%b f%b l%b d%h s%h expected all zero", out_valid, out_first, out_last, out_data, frame_seq);
        end
        @(negedge clk); rst_n = 1;
        @(negedge clk); #1;
        n_assert++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
        n_assert++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL release_out_valid: got %b expected 0", out_valid); end
        clear_logs();
    endtask

    task automatic test_basic();
        logic [33:0] gold [6];
        gold = '{34'h2A5000004, 34'h000020001, 34'h000040003, 34'h000060005, 34'h000080007, 34'h100140010};
        do_reset();
        for (int i = 1; i <= 8; i++) stim.push_back(16'(i));
        run(0, 0, 60, 6);
        n_assert++;
        if (obs.size() != 6) begin n_fail++; $display("FAIL basic_count: got %0d expected 6", obs.size()); end
        for (int i = 0; i < 6 && i < obs.size(); i++) begin
            n_assert++;
            if (obs[i] !== gold[i]) begin n_fail++; $display("FAIL basic_word%0d: got %h expected %h", i, obs[i], gold[i]); end
        end
        n_assert++;
        if (frame_seq !== 8'd1) begin n_fail++; $display("FAIL basic_seq: got %0d expected 1", frame_seq); end
    endtask

    task automatic test_toggle_ready();
        do_reset();
        for (int i = 1; i <= 8; i++) stim.push_back(16'(i));
        run(1, 0, 80, 6);
        build_exp(0);
        n_assert++;
        if (obs.size() != exp_q.size()) begin n_fail++; $display("FAIL toggle_count: got %0d expected %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            n_assert++;
            if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL toggle_word%0d: got %h expected %h", i, obs[i], exp_q[i]); end
        end
        for (int i = 1; i < trace.size(); i++) begin
            if (trace[i-1][35] && !trace[i-1][34]) begin
                n_assert++;
                if (trace[i][35] !== 1'b1 || trace[i][33:0] !== trace[i-1][33:0]) begin
                    n_fail++;
                    $display("FAIL toggle_hold cyc%0d: got v%b %h expected v1 %h", i, trace[i][35], trace[i][33:0], trace[i-1][33:0]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 20; i++) stim.push_back(16'($urandom));
        run(3, 0, 40, 0);
        n_assert++;
        if (acc.size() != 16) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 16", acc.size()); end
        n_assert++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
        run(0, 0, 200, 12);
        build_exp(0);
        n_assert++;
        if (obs.size() != exp_q.size() || obs.size() != 12) begin n_fail++; $display("FAIL bp_count: got %0d expected 12", obs.size()); end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            n_assert++;
            if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_word%0d: got %h expected %h", i, obs[i], exp_q[i]); end
        end
        n_assert++;
        if (obs.size() > 6 && obs[6] !== 34'h2A5010004) begin
            n_fail++; $display("FAIL bp_header2: got %h expected 2a5010004", obs[6]);
        end
    endtask

    task automatic test_checksum_wrap();
        do_reset();
        repeat (8) stim.push_back(16'hFFFF);
        run(2, 0, 100, 6);
        n_assert++;
        if (obs.size() != 6) begin n_fail++; $display("FAIL wrap_count: got %0d expected 6", obs.size()); end
        else begin
            n_assert++;
            if (obs[5] !== 34'h1FFFFFFFC) begin n_fail++; $display("FAIL wrap_checksum: got %h expected 1fffffffc", obs[5]); end
        end
    endtask

    task automatic test_seq_wrap();
        do_reset();
        for (int i = 0; i < 257 * 8; i++) stim.push_back(16'($urandom));
        run(0, 0, 5000, 257 * 6);
        build_exp(0);
        n_assert++;
        if (obs.size() != exp_q.size()) begin n_fail++; $display("FAIL seq_count: got %0d expected %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            n_assert++;
            if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL seq_word%0d: got %h expected %h", i, obs[i], exp_q[i]); end
        end
        if (obs.size() > 1536) begin
            n_assert++;
            if (obs[1530][23:16] !== 8'hFF) begin n_fail++; $display("FAIL seq_256th: got %h expected ff", obs[1530][23:16]); end
            n_assert++;
            if (obs[1536][23:16] !== 8'h00) begin n_fail++; $display("FAIL seq_257th: got %h expected 00", obs[1536][23:16]); end
        end
        n_assert++;
        if (frame_seq !== 8'd1) begin n_fail++; $display("FAIL seq_final: got %0d expected 1", frame_seq); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        for (int i = 0; i < 11; i++) stim.push_back(16'($urandom));
        run(3, 0, 14, 0);
        @(negedge clk); out_ready = 1; #1;
        n_assert++;
        if (!(out_valid && out_first)) begin n_fail++; $display("FAIL mid_header: got v%b f%b expected v1 f1", out_valid, out_first); end
        @(negedge clk); out_ready = 0; #1;
        n_assert++;
        if ({out_valid, out_first, out_data} !== {2'b10, acc[1], acc[0]}) begin
            n_fail++; $display("FAIL mid_payload: got v%b f%b %h expected v1 f0 %h", out_valid, out_first, out_data, {acc[1], acc[0]});
        end
        #2 rst_n = 0;
        #1;
        n_assert++;
        if ({out_valid, in_ready, frame_seq} !== 10'd0) begin
            n_fail++; $display("FAIL mid_async: got v%b r%b s%h expected 0", out_valid, in_ready, frame_seq);
        end
        @(negedge clk); @(negedge clk); rst_n = 1;
        @(negedge clk);
        clear_logs();
        for (int i = 0; i < 8; i++) stim.push_back(16'($urandom));
        run(2, 20, 200, 6);
        build_exp(0);
        n_assert++;
        if (obs.size() != 6) begin n_fail++; $display("FAIL mid_count: got %0d expected 6", obs.size()); end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            n_assert++;
            if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL mid_word%0d: got %h expected %h", i, obs[i], exp_q[i]); end
        end
        n_assert++;
        if (obs.size() > 0 && obs[0] !== 34'h2A5000004) begin n_fail++; $display("FAIL mid_clean_header: got %h expected 2a5000004", obs[0]); end
    endtask

    task automatic test_latency();
        int lat;
        do_reset();
        for (int i = 0; i < 7; i++) stim.push_back(16'($urandom));
        run(0, 0, 40, 0);
        n_assert++;
        if (obs.size() != 0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_no_header: got %0d words v%b expected 0 words v0", obs.size(), out_valid); end
        @(negedge clk); in_valid = 1; in_data = 16'($urandom); #1;
        if (in_ready) acc.push_back(in_data);
        lat = 0;
        do begin
            @(negedge clk); in_valid = 0; #1; lat++;
        end while (!out_valid && lat < 6);
        n_assert++;
        if (!out_valid || lat > 2) begin n_fail++; $display("FAIL lat_header: got %0d cycles v%b expected <=2 v1", lat, out_valid); end
        run(0, 0, 60, 6);
        build_exp(0);
        n_assert++;
        if (obs.size() != exp_q.size() || obs.size() != 6) begin n_fail++; $display("FAIL lat_count: got %0d expected 6", obs.size()); end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            n_assert++;
            if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL lat_word%0d: got %h expected %h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        int n;
        do_reset();
        n = $urandom_range(40, 90);
        for (int i = 0; i < n; i++) stim.push_back(16'($urandom));
        run(2, 30, 3000, ((n / 2) / FW) * (FW + 2));
        build_exp(0);
        n_assert++;
        if (obs.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            n_assert++;
            if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_word%0d: got %h expected %h", i, obs[i], exp_q[i]); end
        end
        n_assert++;
        if (frame_seq !== 8'((n / 2) / FW)) begin n_fail++; $display("FAIL rand_seq: got %0d expected %0d", frame_seq, (n / 2) / FW); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle_ready();
        test_backpressure();
        test_checksum_wrap();
        test_seq_wrap();
        test_reset_mid_frame();
        test_latency();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/sample_framer.md
Name: sample_framer

Overview:
- Downstream consumer of the 16-bit accumulator output stream.
- Pairs consecutive 16-bit samples into 32-bit words and buffers them in an internal FIFO.
- Emits fixed-length frames on a valid/ready output: header word, FRAME_WORDS payload words, then a checksum word.
- Feeds the link/serialiser stage; backpressure propagates upstream via in_ready.

Parameters:
- FRAME_WORDS, 4, payload words per frame; range 1..65535.
- FIFO_DEPTH, 8, payload FIFO depth in 32-bit words; power of 2, >= FRAME_WORDS.
- SYNC_BYTE, 8'hA5, constant in header bits [31:24].

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data holds a sample
- in_ready  output  1  framer accepts a sample this cycle
- in_data  input  16  sample, typically signal_out of the accumulator stage
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- out_data  output  32  header, payload or checksum word
- out_first  output  1  out_data is the header word
- out_last  output  1  out_data is the checksum word
- frame_seq  output  8  number of completed frames, mod 256

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - in_ready=0 while rst_n low, 1 on the first cycle after release.
  - out_valid=0, out_first=0, out_last=0, out_data=0, frame_seq=0.
  - FIFO empty, pair holder empty, state IDLE, checksum=0.
- Reset mid-frame discards all buffered data and the partial pair. No partial frame is emitted after reset.
- Input handshake: sample accepted when in_valid && in_ready.
- in_ready = (fifo_count < FIFO_DEPTH), registered-free combinational from count.
- Pairing:
  - First accepted sample goes to the holding register as bits [15:0].
  - Second accepted sample forms word {sample2, sample1}, pushed into the FIFO in the same cycle. Holder becomes empty.
  - A word is visible to the framer on the next cycle.
- Simultaneous push and pop: fifo_count unchanged. Push and pop pointers wrap modulo FIFO_DEPTH.
- State machine IDLE / HEADER / PAYLOAD / CHECKSUM:
  - IDLE:
    - out_valid=0.
    - Go to HEADER when fifo_count >= FRAME_WORDS. A frame never starts until its full payload is buffered.
  - HEADER:
    - out_valid=1, out_first=1, out_data={SYNC_BYTE, frame_seq, FRAME_WORDS[15:0]}.
    - On handshake: clear checksum and word index, go to PAYLOAD.
  - PAYLOAD:
    - out_valid=1, out_data=FIFO head.
    - On handshake: pop, checksum += word (mod 2^32), increment index.
    - When the index was FRAME_WORDS-1, go to CHECKSUM.
  - CHECKSUM:
    - out_valid=1, out_last=1, out_data=checksum.
    - On handshake: frame_seq += 1 (wraps 255->0), go to IDLE.
- Minimum latency from the FRAME_WORDS-th word pushed to header valid: 2 cycles.
- Back-to-back frames: one IDLE cycle between checksum handshake and next header.
- Output stability: while out_valid && !out_ready, out_data/out_first/out_last hold. Valid never drops without a handshake.
- in_ready stays independent of out_ready except through FIFO fill. Input keeps filling the FIFO during frame emission.
- FRAME_WORDS=1 degenerates to HEADER, one payload word, CHECKSUM equal to that word.

Test Plan:
- Reset, then 8 samples 0x0001..0x0008 with out_ready=1. Required output:
  - header 0xA5000004
  - payload 0x00020001, 0x00040003, 0x00060005, 0x00080007
  - checksum 0x00140010 with out_last=1
  - frame_seq becomes 1
- Same stimulus with out_ready toggling 1/0 every cycle -> identical word sequence; each word held stable while out_ready=0.
- Hold out_ready=0 and stream 20 samples -> in_ready falls after 16 accepted samples (FIFO full). Then release out_ready -> two complete frames, 2nd header 0xA5010004, no sample lost or duplicated.
- Payload words 0xFFFFFFFF x4 -> checksum 0xFFFFFFFC (wrap). Run 256 frames -> frame_seq returns 0, 257th header byte [23:16]=0x00.
- Assert rst_n low mid-PAYLOAD with 3 samples odd-buffered -> out_valid=0 immediately (async). After release, 8 new samples produce a clean frame with header 0xA5000004 and frame_seq=0.
- 7 samples only -> no header. The 8th sample -> header valid within 2 cycles.
